// File: rtl/csa_accum_sequencer.sv
// csa_accum_sequencer: sums a stream of num_ops unsigned N-bit operands through a
// 3:2 carry-save stage, keeps the running total in redundant (sum, carry) form and
// resolves it with one carry-propagate add after the last operand.
// Optional feature macro: CSA_SEQ_ABORT_EN adds an abort input that cancels a job.
module csa_accum_sequencer #(
    parameter  int unsigned N       = 8,
    parameter  int unsigned MAX_OPS = 16,
    localparam int unsigned CW      = $clog2(MAX_OPS),
    localparam int unsigned W       = N + CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW:0]   num_ops,
    output logic          busy,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [N-1:0]  op_data,
    output logic          res_valid,
    input  logic          res_ready,
`ifdef CSA_SEQ_ABORT_EN
    input  logic          abort,
`endif
    output logic [W-1:0]  res_data
);

    localparam int unsigned NW = CW + 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCUM   = 2'd1;
    localparam logic [1:0] RESOLVE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]    state, state_nxt;
    logic [NW-1:0] remaining, remaining_nxt;
    logic [W-1:0]  sum_r, sum_nxt;
    logic [W-1:0]  carry_r, carry_nxt;
    logic [W-1:0]  res_nxt;
    logic [W-1:0]  opnd;
    logic [W-1:0]  maj;
    logic          abort_c;

    // Abort only acts while a job is in flight; in IDLE it is ignored.
`ifdef CSA_SEQ_ABORT_EN
    assign abort_c = abort && (state != IDLE);
`else
    assign abort_c = 1'b0;
`endif

    // Handshake and status outputs decoded from the state register.
    assign busy      = (state != IDLE);
    assign op_ready  = (state == ACCUM) && !abort_c;
    assign res_valid = (state == DONE)  && !abort_c;

    // 3:2 compressor inputs: zero-extended operand and majority (carry) term.
    assign opnd = {{CW{1'b0}}, op_data};
    assign maj  = (opnd & sum_r) | (opnd & carry_r) | (sum_r & carry_r);

    // Next-state and next-register logic.
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        sum_nxt       = sum_r;
        carry_nxt     = carry_r;
        res_nxt       = res_data;
        if (abort_c) begin
            state_nxt     = IDLE;
            remaining_nxt = '0;
            sum_nxt       = '0;
            carry_nxt     = '0;
            res_nxt       = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_ops == '0) begin
                            res_nxt   = '0;
                            state_nxt = DONE;
                        end else begin
                            remaining_nxt = (num_ops > NW'(MAX_OPS)) ? NW'(MAX_OPS) : num_ops;
                            sum_nxt       = '0;
                            carry_nxt     = '0;
                            state_nxt     = ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (op_valid && op_ready) begin
                        sum_nxt       = opnd ^ sum_r ^ carry_r;
                        // Top bit of maj is provably 0, so the shift never loses data.
                        carry_nxt     = maj << 1;
                        remaining_nxt = remaining - NW'(1);
                        if (remaining == NW'(1)) begin
                            state_nxt = RESOLVE;
                        end
                    end
                end
                RESOLVE: begin
                    res_nxt   = sum_r + carry_r;
                    state_nxt = DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            sum_r     <= '0;
            carry_r   <= '0;
            res_data  <= '0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            sum_r     <= sum_nxt;
            carry_r   <= carry_nxt;
            res_data  <= res_nxt;
        end
    end

endmodule

// File: tb/tb_csa_accum_sequencer.sv
// Directed testbench for csa_accum_sequencer (N=8, MAX_OPS=16, W=12).
// Covers the abort path when CSA_SEQ_ABORT_EN is defined.
module tb_csa_accum_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  num_ops;
    logic        busy;
    logic        op_valid;
    logic        op_ready;
    logic [7:0]  op_data;
    logic        res_valid;
    logic        res_ready;
    logic [11:0] res_data;
`ifdef CSA_SEQ_ABORT_EN
    logic        abort;
`endif

    int checks;
    int failures;

    csa_accum_sequencer #(.N(8), .MAX_OPS(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .num_ops  (num_ops),
        .busy     (busy),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_data  (op_data),
        .res_valid(res_valid),
        .res_ready(res_ready),
`ifdef CSA_SEQ_ABORT_EN
        .abort    (abort),
`endif
        .res_data (res_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkd(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%03h expected=0x%03h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [4:0] n);
        start   = 1'b1;
        num_ops = n;
        tick();
        start   = 1'b0;
        num_ops = 5'd0;
    endtask

    // Present one operand after 'gap' idle cycles; it must be accepted at the next edge.
    task automatic feed(input logic [7:0] d, input int gap);
        op_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            tick();
            check1("busy_gap", busy, 1'b1);
        end
        op_valid = 1'b1;
        op_data  = d;
        #1;
        check1("op_ready_accum", op_ready, 1'b1);
        tick();
        op_valid = 1'b0;
    endtask

    task automatic wait_result(input int budget);
        int n;
        n = 0;
        while (!res_valid && n < budget) begin
            tick();
            n++;
        end
        check1("res_valid_timeout", res_valid, 1'b1);
    endtask

    task automatic take_result();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check1("res_valid_after_take", res_valid, 1'b0);
        check1("busy_after_take", busy, 1'b0);
    endtask

    initial begin
        int acc;
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        start     = 1'b0;
        num_ops   = 5'd0;
        op_valid  = 1'b0;
        op_data   = 8'h00;
        res_ready = 1'b0;
`ifdef CSA_SEQ_ABORT_EN
        abort     = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check1("rst_busy", busy, 1'b0);
        check1("rst_op_ready", op_ready, 1'b0);
        check1("rst_res_valid", res_valid, 1'b0);
        checkd("rst_res_data", res_data, 12'h000);
        tick();

        // 1: three back-to-back operands, exact latency
        start_job(5'd3);
        check1("t1_busy", busy, 1'b1);
        feed(8'h01, 0);
        feed(8'h02, 0);
        feed(8'h03, 0);
        check1("t1_resolve_op_ready", op_ready, 1'b0);
        check1("t1_resolve_res_valid", res_valid, 1'b0);
        tick();
        check1("t1_latency_res_valid", res_valid, 1'b1);
        checkd("t1_res_data", res_data, 12'h006);
        take_result();

        // 2: sixteen 0xFF operands, full width without truncation
        start_job(5'd16);
        for (int i = 0; i < 16; i++) feed(8'hFF, 0);
        wait_result(4);
        checkd("t2_res_data", res_data, 12'hFF0);
        take_result();

        // 3: operand gaps and a stalled consumer
        start_job(5'd3);
        feed(8'hAA, 2);
        feed(8'h55, 1);
        feed(8'h33, 3);
        wait_result(4);
        for (int i = 0; i < 5; i++) begin
            checkd("t3_res_data_held", res_data, 12'h132);
            check1("t3_res_valid_held", res_valid, 1'b1);
            check1("t3_op_ready_done", op_ready, 1'b0);
            check1("t3_busy_done", busy, 1'b1);
            op_valid = 1'b1;
            tick();
        end
        op_valid = 1'b0;
        checkd("t3_res_data_final", res_data, 12'h132);
        take_result();

        // 4a: zero-operand job goes straight to DONE with 0
        start_job(5'd0);
        check1("t4_zero_res_valid", res_valid, 1'b1);
        check1("t4_zero_op_ready", op_ready, 1'b0);
        checkd("t4_zero_res_data", res_data, 12'h000);
        take_result();

        // 4b: num_ops=20 clamps to 16 accepted operands
        start_job(5'd20);
        acc      = 0;
        op_valid = 1'b1;
        op_data  = 8'h10;
        for (int i = 0; i < 40 && !res_valid; i++) begin
            if (op_ready) acc++;
            tick();
        end
        op_valid = 1'b0;
        checkd("t4_clamp_count", 12'(acc), 12'd16);
        check1("t4_clamp_res_valid", res_valid, 1'b1);
        checkd("t4_clamp_res_data", res_data, 12'h100);
        take_result();

        // 5: reset mid-job discards it, then a fresh job
        start_job(5'd4);
        feed(8'h77, 0);
        feed(8'h88, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check1("t5_rst_busy", busy, 1'b0);
        check1("t5_rst_op_ready", op_ready, 1'b0);
        check1("t5_rst_res_valid", res_valid, 1'b0);
        checkd("t5_rst_res_data", res_data, 12'h000);
        start_job(5'd3);
        feed(8'h12, 0);
        feed(8'h34, 0);
        feed(8'h56, 0);
        wait_result(4);
        checkd("t5_res_data", res_data, 12'h09C);
        take_result();

`ifdef CSA_SEQ_ABORT_EN
        // 6a: abort during ACCUM blocks the operand and returns to IDLE
        start_job(5'd2);
        feed(8'h09, 0);
        op_valid = 1'b1;
        op_data  = 8'h0A;
        abort    = 1'b1;
        #1;
        check1("t6_abort_op_ready", op_ready, 1'b0);
        check1("t6_abort_res_valid", res_valid, 1'b0);
        tick();
        abort    = 1'b0;
        op_valid = 1'b0;
        check1("t6_abort_busy", busy, 1'b0);
        check1("t6_abort_no_result", res_valid, 1'b0);
        checkd("t6_abort_res_data", res_data, 12'h000);

        // 6b: start while in DONE is ignored
        start_job(5'd1);
        feed(8'h05, 0);
        wait_result(4);
        start_job(5'd3);
        check1("t6_done_start_ignored", res_valid, 1'b1);
        checkd("t6_done_res_data", res_data, 12'h005);
        take_result();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
